// File: rtl/img_buf_streamer.sv
// Image buffer read streamer: fetches a run of rows and unpacks each into pixels, LSB first.
// Optional IMG_STREAM_PREFETCH_EN adds a second row register so rows stream back-to-back.
module img_buf_streamer #(
  parameter int PIX_W  = 8,
  parameter int WORD_W = 640,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_row,
  input  logic [ADDR_W:0]   num_rows,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [WORD_W-1:0] buf_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int PPR   = WORD_W / PIX_W;
  localparam int CNT_W = (PPR > 1) ? $clog2(PPR) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(PPR - 1);
  localparam logic [CNT_W-1:0]  PEN_PIX  = CNT_W'((PPR > 1) ? PPR - 2 : 0);
  localparam logic              ONE_PIX  = (PPR == 1);
  localparam logic [ADDR_W:0]   MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ROW_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   ROW_TWO  = (ADDR_W+1)'(2);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DONE} state_t;

  state_t              state_r;
  logic [WORD_W-1:0]   shift_r;
  logic [CNT_W-1:0]    pix_cnt_r;
  logic [ADDR_W:0]     rows_left_r;
  logic [ADDR_W-1:0]   fetch_addr_r;
  logic [ADDR_W:0]     n_sat_s;
  logic                hs_s;
  logic                last_pix_s;
`ifdef IMG_STREAM_PREFETCH_EN
  logic [WORD_W-1:0]   nxt_row_r;
  logic                nxt_vld_r;
  logic [1:0]          pf_stage_r;
  logic [ADDR_W:0]     fetch_left_r;
`endif

  assign n_sat_s    = (num_rows > MAX_ROWS) ? MAX_ROWS : num_rows;
  assign hs_s       = pix_valid & pix_ready;
  assign last_pix_s = (pix_cnt_r == LAST_PIX);
  assign pix_data   = shift_r[PIX_W-1:0];

  // Transfer FSM, row shift register and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      shift_r      <= {WORD_W{1'b0}};
      pix_cnt_r    <= {CNT_W{1'b0}};
      rows_left_r  <= {(ADDR_W+1){1'b0}};
      fetch_addr_r <= {ADDR_W{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      buf_raddr    <= {ADDR_W{1'b0}};
      pix_valid    <= 1'b0;
      pix_eol      <= 1'b0;
      pix_eof      <= 1'b0;
`ifdef IMG_STREAM_PREFETCH_EN
      nxt_row_r    <= {WORD_W{1'b0}};
      nxt_vld_r    <= 1'b0;
      pf_stage_r   <= 2'd0;
      fetch_left_r <= {(ADDR_W+1){1'b0}};
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            if (n_sat_s == {(ADDR_W+1){1'b0}}) begin
              state_r <= DONE;
              done    <= 1'b1;
            end else begin
              state_r      <= FETCH;
              busy         <= 1'b1;
              buf_raddr    <= base_row;
              fetch_addr_r <= base_row + ADDR_W'(1);
              rows_left_r  <= n_sat_s;
`ifdef IMG_STREAM_PREFETCH_EN
              fetch_left_r <= n_sat_s - ROW_ONE;
`endif
            end
          end
        end
        FETCH: state_r <= LOAD;
        LOAD: begin
          state_r   <= STREAM;
          shift_r   <= buf_rdata;
          pix_cnt_r <= {CNT_W{1'b0}};
          pix_valid <= 1'b1;
          pix_eol   <= ONE_PIX;
          pix_eof   <= ONE_PIX && (rows_left_r == ROW_ONE);
        end
        STREAM: begin
          if (hs_s && last_pix_s) begin
            if (rows_left_r == ROW_ONE) begin
              state_r   <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pix_valid <= 1'b0;
              pix_eol   <= 1'b0;
              pix_eof   <= 1'b0;
            end else begin
              rows_left_r <= rows_left_r - ROW_ONE;
`ifdef IMG_STREAM_PREFETCH_EN
              // Next row is already resident; hand it over with no bubble.
              shift_r     <= nxt_row_r;
              nxt_vld_r   <= 1'b0;
              pix_cnt_r   <= {CNT_W{1'b0}};
              pix_eol     <= ONE_PIX;
              pix_eof     <= ONE_PIX && (rows_left_r == ROW_TWO);
`else
              state_r      <= FETCH;
              buf_raddr    <= fetch_addr_r;
              fetch_addr_r <= fetch_addr_r + ADDR_W'(1);
              pix_valid    <= 1'b0;
              pix_eol      <= 1'b0;
              pix_eof      <= 1'b0;
`endif
            end
          end else if (hs_s) begin
            shift_r   <= shift_r >> PIX_W;
            pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            pix_eol   <= (pix_cnt_r == PEN_PIX);
            pix_eof   <= (pix_cnt_r == PEN_PIX) && (rows_left_r == ROW_ONE);
          end else begin
            shift_r <= shift_r;
          end
        end
        DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
`ifdef IMG_STREAM_PREFETCH_EN
      // Prefetch pipe: address out, RAM read, capture into the spare row register.
      if (pf_stage_r == 2'd2) begin
        nxt_row_r  <= buf_rdata;
        nxt_vld_r  <= 1'b1;
        pf_stage_r <= 2'd0;
      end else if (pf_stage_r == 2'd1) begin
        pf_stage_r <= 2'd2;
      end else if (state_r == STREAM && fetch_left_r != {(ADDR_W+1){1'b0}} && !nxt_vld_r) begin
        buf_raddr    <= fetch_addr_r;
        fetch_addr_r <= fetch_addr_r + ADDR_W'(1);
        fetch_left_r <= fetch_left_r - ROW_ONE;
        pf_stage_r   <= 2'd1;
      end else begin
        pf_stage_r <= pf_stage_r;
      end
`endif
    end
  end

endmodule

// File: tb/tb_img_buf_streamer.sv
// Directed self-checking bench for img_buf_streamer with a registered-read RAM model.
// Timing expectations follow IMG_STREAM_PREFETCH_EN when it is defined.
module tb_img_buf_streamer;

`ifdef IMG_STREAM_PREFETCH_EN
  localparam int EXP_GAP = 0;
  localparam int EXP_T3  = 242;
`else
  localparam int EXP_GAP = 2;
  localparam int EXP_T3  = 246;
`endif

  logic         clk = 1'b0;
  logic         rst, start, busy, done, pix_valid, pix_ready, pix_eol, pix_eof;
  logic [8:0]   base_row, buf_raddr;
  logic [9:0]   num_rows;
  logic [639:0] buf_rdata;
  logic [7:0]   pix_data;
  logic [639:0] mem [512];

  int vec = 0, err = 0, cyc = 0;

  logic [7:0] q_data[$];
  bit         q_eol[$], q_eof[$];
  int         q_cyc[$];
  logic [8:0] q_addr[$];
  logic [8:0] last_addr;
  logic [9:0] prev_out;
  bit         mon_en = 1'b0, stall_prev = 1'b0, done_busy = 1'b0;
  int         done_cnt = 0, done_cyc = 0, stab_err = 0;

  img_buf_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_row(base_row), .num_rows(num_rows),
    .busy(busy), .done(done), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) buf_rdata <= mem[buf_raddr];

  // Passive monitor: handshakes, done pulses, address changes, stall stability
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev && (!pix_valid || {pix_data, pix_eol, pix_eof} != prev_out)) stab_err++;
      stall_prev = pix_valid && !pix_ready;
      prev_out   = {pix_data, pix_eol, pix_eof};
      if (pix_valid && pix_ready) begin
        q_data.push_back(pix_data); q_eol.push_back(pix_eol);
        q_eof.push_back(pix_eof);   q_cyc.push_back(cyc + 1);
      end
      if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
      if (buf_raddr != last_addr) begin q_addr.push_back(buf_raddr); last_addr = buf_raddr; end
    end
  end

  function automatic logic [7:0] exp_pix(int row, int k);
    return 8'(((row % 512) * 80 + k) & 255);
  endfunction

  task automatic clear_mon();
    q_data.delete(); q_eol.delete(); q_eof.delete(); q_cyc.delete(); q_addr.delete();
    done_cnt = 0; stab_err = 0; stall_prev = 1'b0; last_addr = buf_raddr; mon_en = 1'b1;
  endtask

  task automatic run_xfer(input logic [8:0] b, input logic [9:0] n, input bit rnd,
                          input int budget, output int t0, output bit tmo);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_row = b; num_rows = n;
    pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; t0 = cyc;
    tmo = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != 0) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
      if (rnd) pix_ready = 1'($urandom_range(0, 1));
    end
    pix_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_row = 9'd0; num_rows = 10'd0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++; if ({busy, done, pix_valid, pix_eol, pix_eof} !== 5'b0) begin err++;
      $display("FAIL reset_flags got %b want 00000", {busy, done, pix_valid, pix_eol, pix_eof}); end
    vec++; if ({buf_raddr, pix_data} !== 17'd0) begin err++;
      $display("FAIL reset_data got raddr=%0d pix=%0h want 0", buf_raddr, pix_data); end
    rst = 1'b0;
  endtask

  task automatic test_single_row();
    int t0; bit tmo; int neol = 0;
    run_xfer(9'd0, 10'd1, 1'b0, 200, t0, tmo);
    vec++; if (tmo !== 1'b0) begin err++; $display("FAIL single_timeout got no done want done"); end
    vec++; if (q_data.size() !== 80) begin err++; $display("FAIL single_count got %0d want 80", q_data.size()); end
    for (int k = 0; k < q_data.size(); k++) begin
      vec++; if (q_data[k] !== 8'(k)) begin err++; $display("FAIL single_pix[%0d] got %0h want %0h", k, q_data[k], k); end
      if (q_eol[k]) neol++;
    end
    vec++; if (neol !== 1 || q_eol[79] !== 1'b1 || q_eof[79] !== 1'b1) begin err++;
      $display("FAIL single_eol got eol_cnt=%0d eol79=%b eof79=%b want 1 1 1", neol, q_eol[79], q_eof[79]); end
    vec++; if (q_cyc[0] - t0 !== 3) begin err++; $display("FAIL single_first_lat got %0d want 3", q_cyc[0] - t0); end
    vec++; if (q_cyc[79] - t0 !== 82) begin err++; $display("FAIL single_last_lat got %0d want 82", q_cyc[79] - t0); end
    vec++; if (done_cyc !== q_cyc[79] || done_busy !== 1'b0 || done_cnt !== 1) begin err++;
      $display("FAIL single_done got cyc=%0d busy=%b cnt=%0d want cyc=%0d busy=0 cnt=1", done_cyc, done_busy, done_cnt, q_cyc[79]); end
  endtask

  task automatic test_wrap();
    int t0; bit tmo; int neol = 0;
    logic [8:0] exp_a [4];
    exp_a[0] = 9'd510; exp_a[1] = 9'd511; exp_a[2] = 9'd0; exp_a[3] = 9'd1;
    run_xfer(9'd510, 10'd4, 1'b0, 1000, t0, tmo);
    vec++; if (tmo !== 1'b0 || q_data.size() !== 320) begin err++;
      $display("FAIL wrap_count got tmo=%b n=%0d want 0 320", tmo, q_data.size()); end
    vec++; if (q_addr.size() !== 4) begin err++; $display("FAIL wrap_naddr got %0d want 4", q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      vec++; if (q_addr[i] !== exp_a[i]) begin err++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, q_addr[i], exp_a[i]); end
    end
    for (int p = 0; p < q_data.size(); p++) begin
      vec++; if (q_data[p] !== exp_pix(510 + p / 80, p % 80) || q_eol[p] !== (p % 80 == 79) || q_eof[p] !== (p == 319)) begin
        err++; $display("FAIL wrap_pix[%0d] got %0h/%b/%b want %0h/%b/%b", p, q_data[p], q_eol[p], q_eof[p],
                        exp_pix(510 + p / 80, p % 80), (p % 80 == 79), (p == 319)); end
      if (q_eol[p]) neol++;
    end
    vec++; if (neol !== 4) begin err++; $display("FAIL wrap_eol_cnt got %0d want 4", neol); end
  endtask

  task automatic test_backpressure();
    int t0; bit tmo;
    run_xfer(9'd100, 10'd2, 1'b1, 3000, t0, tmo);
    vec++; if (tmo !== 1'b0 || q_data.size() !== 160) begin err++;
      $display("FAIL bp_count got tmo=%b n=%0d want 0 160", tmo, q_data.size()); end
    for (int p = 0; p < q_data.size(); p++) begin
      vec++; if (q_data[p] !== exp_pix(100 + p / 80, p % 80) || q_eof[p] !== (p == 159)) begin err++;
        $display("FAIL bp_pix[%0d] got %0h eof=%b want %0h", p, q_data[p], q_eof[p], exp_pix(100 + p / 80, p % 80)); end
    end
    vec++; if (stab_err !== 0) begin err++; $display("FAIL bp_stable got %0d violations want 0", stab_err); end
  endtask

  task automatic test_zero_rows();
    int t0; bit tmo;
    run_xfer(9'd7, 10'd0, 1'b0, 20, t0, tmo);
    vec++; if (tmo !== 1'b0 || done_cyc !== t0 || done_busy !== 1'b0) begin err++;
      $display("FAIL zero_done got tmo=%b dcyc=%0d busy=%b want 0 %0d 0", tmo, done_cyc - t0 + t0, done_busy, t0); end
    vec++; if (q_data.size() !== 0 || q_addr.size() !== 0) begin err++;
      $display("FAIL zero_quiet got pix=%0d addr=%0d want 0 0", q_data.size(), q_addr.size()); end
  endtask

  task automatic test_abort();
    int t0; bit tmo;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; base_row = 9'd20; num_rows = 10'd4; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 400 && q_data.size() < 120; i++) @(posedge clk);
    #1;
    vec++; if (q_data.size() < 120 || done_cnt !== 0) begin err++;
      $display("FAIL abort_midrow got n=%0d done=%0d want >=120 0", q_data.size(), done_cnt); end
    rst = 1'b1;
    @(posedge clk); #1;
    vec++; if ({busy, done, pix_valid, pix_eol, pix_eof, buf_raddr, pix_data} !== 22'd0) begin err++;
      $display("FAIL abort_outputs got %0h want 0", {busy, done, pix_valid, pix_eol, pix_eof, buf_raddr, pix_data}); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    vec++; if (done_cnt !== 0) begin err++; $display("FAIL abort_nodone got %0d want 0", done_cnt); end
    run_xfer(9'd30, 10'd1, 1'b0, 200, t0, tmo);
    vec++; if (tmo !== 1'b0 || q_data.size() !== 80 || done_cnt !== 1) begin err++;
      $display("FAIL abort_restart got tmo=%b n=%0d done=%0d want 0 80 1", tmo, q_data.size(), done_cnt); end
    for (int p = 0; p < q_data.size(); p++) begin
      vec++; if (q_data[p] !== exp_pix(30, p)) begin err++;
        $display("FAIL abort_pix[%0d] got %0h want %0h", p, q_data[p], exp_pix(30, p)); end
    end
  endtask

  task automatic test_gap();
    int t0; bit tmo;
    run_xfer(9'd200, 10'd3, 1'b0, 1000, t0, tmo);
    vec++; if (tmo !== 1'b0 || q_cyc.size() !== 240) begin err++;
      $display("FAIL gap_count got tmo=%b n=%0d want 0 240", tmo, q_cyc.size()); end
    vec++; if (q_cyc[80] - q_cyc[79] - 1 !== EXP_GAP || q_cyc[160] - q_cyc[159] - 1 !== EXP_GAP) begin err++;
      $display("FAIL gap_rows got %0d,%0d want %0d", q_cyc[80] - q_cyc[79] - 1, q_cyc[160] - q_cyc[159] - 1, EXP_GAP); end
    vec++; if (q_cyc[239] - t0 !== EXP_T3) begin err++;
      $display("FAIL gap_total got %0d want %0d", q_cyc[239] - t0, EXP_T3); end
  endtask

  initial begin
    for (int r = 0; r < 512; r++)
      for (int k = 0; k < 80; k++)
        mem[r][k*8 +: 8] = 8'((r * 80 + k) & 255);
    test_reset();
    test_single_row();
    test_wrap();
    test_backpressure();
    test_zero_rows();
    test_abort();
    test_gap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
